// File: rtl/reg_space_array_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_space_array_pkg: register modes, read-FSM states, addr decode   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package reg_space_array_pkg;

  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    MODE_RW  = 2'd0,
    MODE_RO  = 2'd1,
    MODE_W1C = 2'd2
  } reg_mode_e;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_ACK  = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } addr_dec_t;

  // Only exact multiples of the stride below the register count are mapped.
  function automatic addr_dec_t decode_addr(input logic [31:0] addr,
                                            input logic [31:0] stride,
                                            input logic [31:0] num_regs);
    addr_dec_t   dec;
    logic [31:0] slot;
    slot    = addr / stride;
    dec.hit = ((addr % stride) == 32'd0) && (slot < num_regs);
    dec.idx = slot[IDX_W-1:0];
    return dec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_space_array_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_space_array_if: software read/write bus of the register array   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface reg_space_array_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   rreq_addr;
  logic                rreq_vld;
  logic                rreq_rdy;
  logic [DATA_W-1:0]   rack_data;
  logic                rack_err;
  logic                rack_vld;
  logic                rack_rdy;
  logic [ADDR_W-1:0]   wreq_addr;
  logic [DATA_W-1:0]   wreq_data;
  logic [DATA_W/8-1:0] wreq_strb;
  logic                wreq_vld;
  logic                wreq_rdy;
  logic                wack_err;

  modport master (
    output rreq_addr, rreq_vld, rack_rdy, wreq_addr, wreq_data, wreq_strb, wreq_vld,
    input  rreq_rdy, rack_data, rack_err, rack_vld, wreq_rdy, wack_err
  );

  modport slave (
    input  rreq_addr, rreq_vld, rack_rdy, wreq_addr, wreq_data, wreq_strb, wreq_vld,
    output rreq_rdy, rack_data, rack_err, rack_vld, wreq_rdy, wack_err
  );
endinterface
`default_nettype wire

// File: rtl/reg_space_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_space_cell: one register with byte-strobe merge and RW/RO/W1C   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module reg_space_cell
  import reg_space_array_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter reg_mode_e         MODE    = MODE_RW,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_we,
  input  logic [DATA_W-1:0]   sw_data,
  input  logic [DATA_W/8-1:0] sw_strb,
  input  logic                hw_we,
  input  logic [DATA_W-1:0]   hw_data,
  output logic [DATA_W-1:0]   value,
  output logic                sw_wr_pulse
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] value_q, value_d;
  logic              pulse_q, pulse_d;
  logic [DATA_W-1:0] byte_mask;

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < NB; b++) byte_mask[b*8 +: 8] = {8{sw_strb[b]}};
    value_d = value_q;
    case (MODE)
      MODE_RO: begin
        if (hw_we) value_d = hw_data;
      end
      MODE_W1C: begin
        // Clear first, then set, so a coincident set wins.
        if (sw_we) value_d = value_d & ~(sw_data & byte_mask);
        if (hw_we) value_d = value_d | hw_data;
      end
      default: begin
        if (hw_we) value_d = hw_data;
        if (sw_we) value_d = (value_d & ~byte_mask) | (sw_data & byte_mask);
      end
    endcase
    pulse_d = sw_we && (MODE != MODE_RO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= RST_VAL;
      pulse_q <= 1'b0;
    end else begin
      value_q <= value_d;
      pulse_q <= pulse_d;
    end
  end

  assign value       = value_q;
  assign sw_wr_pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/reg_space_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_space_array: software-mapped register array with HW update path |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module reg_space_array
  import reg_space_array_pkg::*;
#(
  parameter int                         NUM_REGS    = 4,
  parameter int                         DATA_W      = 32,
  parameter int                         ADDR_W      = 16,
  parameter int                         ADDR_STRIDE = 32,
  parameter logic [2*NUM_REGS-1:0]      REG_MODE    = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL     = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  reg_space_array_if.slave             bus,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_wdat,
  input  logic [NUM_REGS-1:0]          hw_wvld,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          sw_wr_pulse
);

  addr_dec_t         rd_dec, wr_dec;
  logic [NUM_REGS-1:0] ro_hit;
  logic [DATA_W-1:0] rd_word;

  rd_state_e         state_q, state_d;
  logic [DATA_W-1:0] rack_data_q, rack_data_d;
  logic              rack_err_q, rack_err_d;
  logic              wack_err_q, wack_err_d;

  assign rd_dec = decode_addr(32'(bus.rreq_addr), 32'(ADDR_STRIDE), 32'(NUM_REGS));
  assign wr_dec = decode_addr(32'(bus.wreq_addr), 32'(ADDR_STRIDE), 32'(NUM_REGS));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam reg_mode_e MODE_I = reg_mode_e'(REG_MODE[2*i +: 2]);
    logic sel;
    assign sel       = bus.wreq_vld && wr_dec.hit && (wr_dec.idx == IDX_W'(i));
    assign ro_hit[i] = sel && (MODE_I == MODE_RO);

    reg_space_cell #(
      .DATA_W  (DATA_W),
      .MODE    (MODE_I),
      .RST_VAL (RST_VAL[i*DATA_W +: DATA_W])
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .sw_we       (sel),
      .sw_data     (bus.wreq_data),
      .sw_strb     (bus.wreq_strb),
      .hw_we       (hw_wvld[i]),
      .hw_data     (hw_wdat[i*DATA_W +: DATA_W]),
      .value       (reg_q[i*DATA_W +: DATA_W]),
      .sw_wr_pulse (sw_wr_pulse[i])
    );
  end

  // Muxing the current contents yields the pre-write value on a same-cycle write.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_dec.hit && (rd_dec.idx == IDX_W'(i))) rd_word = reg_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    rack_data_d = rack_data_q;
    rack_err_d  = rack_err_q;
    wack_err_d  = bus.wreq_vld && (!wr_dec.hit || (|ro_hit));
    case (state_q)
      RD_IDLE: begin
        if (bus.rreq_vld) begin
          rack_data_d = rd_word;
          rack_err_d  = !rd_dec.hit;
          state_d     = RD_ACK;
        end
      end
      RD_ACK: begin
        if (bus.rack_rdy) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RD_IDLE;
      rack_data_q <= '0;
      rack_err_q  <= 1'b0;
      wack_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rack_data_q <= rack_data_d;
      rack_err_q  <= rack_err_d;
      wack_err_q  <= wack_err_d;
    end
  end

  assign bus.rreq_rdy  = (state_q == RD_IDLE);
  assign bus.rack_vld  = (state_q == RD_ACK);
  assign bus.rack_data = rack_data_q;
  assign bus.rack_err  = rack_err_q;
  assign bus.wreq_rdy  = 1'b1;
  assign bus.wack_err  = wack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_space_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reg_space_array: randomized bench against a behavioural model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_reg_space_array;

  localparam logic [7:0]   MODES = 8'b01_10_00_00;
  localparam logic [127:0] RSTV  = {32'hCAFE_0003, 32'h0000_000F, 32'hA5A5_1234, 32'h0000_0000};

  logic         clk;
  logic         rst;
  logic [127:0] hw_wdat;
  logic [3:0]   hw_wvld;
  wire  [127:0] reg_q;
  wire  [3:0]   sw_wr_pulse;

  reg_space_array_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  reg_space_array #(
    .NUM_REGS    (4),
    .DATA_W      (32),
    .ADDR_W      (16),
    .ADDR_STRIDE (32),
    .REG_MODE    (MODES),
    .RST_VAL     (RSTV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .hw_wdat     (hw_wdat),
    .hw_wvld     (hw_wvld),
    .reg_q       (reg_q),
    .sw_wr_pulse (sw_wr_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_reg [4];
  logic        m_busy;
  logic [31:0] m_rdata;
  logic        m_rerr;
  logic [3:0]  m_pulse;
  logic        m_werr;
  logic [31:0] d0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] mode_of(input int i);
    case (i)
      2:       return 2'd2;
      3:       return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic mapped(input logic [15:0] a);
    return ((a % 16'd32) == 16'd0) && ((a / 16'd32) < 16'd4);
  endfunction

  task automatic model_reset();
    logic [127:0] rv;
    rv = RSTV;
    for (int i = 0; i < 4; i++) m_reg[i] = rv[i*32 +: 32];
    m_busy  = 1'b0;
    m_rdata = '0;
    m_rerr  = 1'b0;
    m_pulse = '0;
    m_werr  = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.rreq_addr = '0;
    bus.rreq_vld  = 1'b0;
    bus.rack_rdy  = 1'b0;
    bus.wreq_addr = '0;
    bus.wreq_data = '0;
    bus.wreq_strb = '0;
    bus.wreq_vld  = 1'b0;
    hw_wdat       = '0;
    hw_wvld       = '0;
  endtask

  // One clock: predict from the current inputs, advance, then compare everything.
  task automatic cycle();
    logic [31:0] nreg [4];
    logic        nbusy, nrerr, nwerr, wmap;
    logic [31:0] nrdata;
    logic [3:0]  npulse;
    int          widx, ridx;

    nbusy  = m_busy;
    nrdata = m_rdata;
    nrerr  = m_rerr;
    if (!m_busy && bus.rreq_vld) begin
      nbusy  = 1'b1;
      nrerr  = !mapped(bus.rreq_addr);
      nrdata = 32'h0;
      if (!nrerr) begin
        ridx   = int'(bus.rreq_addr) / 32;
        nrdata = m_reg[ridx];
      end
    end else if (m_busy && bus.rack_rdy) begin
      nbusy = 1'b0;
    end

    wmap   = mapped(bus.wreq_addr);
    widx   = int'(bus.wreq_addr) / 32;
    nwerr  = bus.wreq_vld && (!wmap || (mode_of(widx) == 2'd1));
    npulse = '0;
    for (int i = 0; i < 4; i++) begin
      logic        sw;
      logic [31:0] hd, v;
      sw = bus.wreq_vld && wmap && (widx == i);
      hd = hw_wdat[i*32 +: 32];
      v  = m_reg[i];
      case (mode_of(i))
        2'd0: begin
          for (int b = 0; b < 4; b++) begin
            if (sw && bus.wreq_strb[b]) v[b*8 +: 8] = bus.wreq_data[b*8 +: 8];
            else if (hw_wvld[i])        v[b*8 +: 8] = hd[b*8 +: 8];
          end
          npulse[i] = sw;
        end
        2'd1: begin
          if (hw_wvld[i]) v = hd;
        end
        default: begin
          for (int k = 0; k < 32; k++) begin
            if (hw_wvld[i] && hd[k]) v[k] = 1'b1;
            else if (sw && bus.wreq_strb[k/8] && bus.wreq_data[k]) v[k] = 1'b0;
          end
          npulse[i] = sw;
        end
      endcase
      nreg[i] = v;
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) m_reg[i] = nreg[i];
    m_busy  = nbusy;
    m_rdata = nrdata;
    m_rerr  = nrerr;
    m_pulse = npulse;
    m_werr  = nwerr;

    chk("reg_q", reg_q, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
    chk("sw_wr_pulse", sw_wr_pulse, m_pulse);
    chk("wack_err", bus.wack_err, m_werr);
    chk("wreq_rdy", bus.wreq_rdy, 1'b1);
    chk("rack_vld", bus.rack_vld, m_busy);
    chk("rreq_rdy", bus.rreq_rdy, !m_busy);
    if (m_busy) begin
      chk("rack_data", bus.rack_data, m_rdata);
      chk("rack_err", bus.rack_err, m_rerr);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_q", reg_q, RSTV);
    chk("rst_rack_vld", bus.rack_vld, 1'b0);
    chk("rst_rack_data", bus.rack_data, 32'h0);
    chk("rst_rack_err", bus.rack_err, 1'b0);
    chk("rst_wack_err", bus.wack_err, 1'b0);
    chk("rst_pulse", sw_wr_pulse, 4'h0);
    rst = 1'b0;
    #1;
    chk("rst_rreq_rdy", bus.rreq_rdy, 1'b1);
    cycle();

    // Read reg 1 after reset
    bus.rreq_addr = 16'h0020;
    bus.rreq_vld  = 1'b1;
    bus.rack_rdy  = 1'b1;
    cycle();
    chk("rd1_vld", bus.rack_vld, 1'b1);
    chk("rd1_data", bus.rack_data, 32'hA5A5_1234);
    chk("rd1_err", bus.rack_err, 1'b0);
    bus.rreq_vld = 1'b0;
    cycle();

    // RW byte strobes
    bus.wreq_addr = 16'h0000;
    bus.wreq_data = 32'hFFFF_FFFF;
    bus.wreq_strb = 4'b0101;
    bus.wreq_vld  = 1'b1;
    cycle();
    chk("rw_strb_q", reg_q[31:0], 32'h00FF_00FF);
    chk("rw_pulse", sw_wr_pulse, 4'b0001);
    bus.wreq_vld = 1'b0;
    cycle();
    chk("rw_pulse_end", sw_wr_pulse, 4'b0000);

    // W1C clear with coincident hardware set
    bus.wreq_addr = 16'h0040;
    bus.wreq_data = 32'h3;
    bus.wreq_strb = 4'hF;
    bus.wreq_vld  = 1'b1;
    hw_wvld       = 4'b0100;
    hw_wdat       = 128'h1 << 64;
    cycle();
    chk("w1c_q", reg_q[95:64], 32'h0000_000D);
    clear_inputs();
    cycle();

    // Unmapped read, write to RO
    bus.rreq_addr = 16'h1000;
    bus.rreq_vld  = 1'b1;
    bus.rack_rdy  = 1'b1;
    cycle();
    chk("unm_err", bus.rack_err, 1'b1);
    chk("unm_data", bus.rack_data, 32'h0);
    bus.rreq_vld  = 1'b0;
    bus.wreq_addr = 16'h0060;
    bus.wreq_data = 32'h1234_5678;
    bus.wreq_strb = 4'hF;
    bus.wreq_vld  = 1'b1;
    cycle();
    chk("ro_werr", bus.wack_err, 1'b1);
    chk("ro_q", reg_q[127:96], 32'hCAFE_0003);
    chk("ro_pulse", sw_wr_pulse, 4'b0000);
    bus.wreq_vld = 1'b0;
    cycle();
    chk("ro_werr_end", bus.wack_err, 1'b0);

    // Backpressure, then reset while a response is pending
    bus.rreq_addr = 16'h0020;
    bus.rreq_vld  = 1'b1;
    bus.rack_rdy  = 1'b0;
    cycle();
    d0 = bus.rack_data;
    repeat (5) begin
      cycle();
      chk("hold_data", bus.rack_data, d0);
      chk("hold_rdy", bus.rreq_rdy, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk("rst_ack_vld", bus.rack_vld, 1'b0);
    chk("rst_ack_data", bus.rack_data, 32'h0);
    chk("rst_ack_q", reg_q, RSTV);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    clear_inputs();
    repeat (3) cycle();

    // Randomized traffic
    repeat (800) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: bus.rreq_addr = 16'($urandom_range(0, 3) * 32);
        4:          bus.rreq_addr = 16'h0080;
        default:    bus.rreq_addr = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0, 1, 2, 3: bus.wreq_addr = 16'($urandom_range(0, 3) * 32);
        4:          bus.wreq_addr = 16'h0080;
        default:    bus.wreq_addr = 16'($urandom);
      endcase
      bus.rreq_vld  = 1'($urandom_range(0, 1));
      bus.rack_rdy  = ($urandom_range(0, 9) < 7);
      bus.wreq_vld  = 1'($urandom_range(0, 1));
      bus.wreq_data = $urandom;
      bus.wreq_strb = 4'($urandom);
      hw_wdat       = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) hw_wvld[i] = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
